// File: rtl/chan_coef_load_ctrl.sv
// Purpose : loads N pulse-response words from the coefficient ROM into the ISI channel, waits for done_wait, then gates symbols.
// Latency : first ROM read 1 cycle after start; N+2 channel writes from cycle 2; RUN at least 1 cycle after the last write.
// Backpr. : src_ready is low outside RUN, so no symbol reaches the channel during a load, wait or error.
//
// Ports:
//   clk, rstn             clock, async active-low reset (released synchronously inside the block)
//   start                 single-cycle load/reload/retry request (ignored while busy)
//   rom_rd_en/addr/rdata  coefficient ROM read port; rdata valid one cycle after rd_en
//   load_mem/location/mem_data  channel coefficient write port
//   done_wait             channel reports its coefficient load is complete
//   src_valid/src_ready   symbol handshake from TX; chan_valid is their AND
//   busy/cfg_done/cfg_error  status: loading or waiting / running / timed out
module chan_coef_load_ctrl #(
    parameter int PULSE_RESPONSE_LENGTH = 5,
    parameter int ADDR_WIDTH            = 8,
    parameter int BASE_ADDR             = 0,
    parameter int DONE_TIMEOUT          = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    output logic                  rom_rd_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [63:0]           rom_rdata,
    output logic                  load_mem,
    output logic [7:0]            location,
    output logic [63:0]           mem_data,
    input  logic                  done_wait,
    input  logic                  src_valid,
    output logic                  src_ready,
    output logic                  chan_valid,
    output logic                  busy,
    output logic                  cfg_done,
    output logic                  cfg_error
);

    localparam int N   = PULSE_RESPONSE_LENGTH;
    localparam int LCW = $clog2(N + 3);
    localparam int TCW = $clog2(DONE_TIMEOUT + 1);
    localparam logic [TCW-1:0] TMO_LAST = TCW'(DONE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        WAIT_DONE = 3'd2,
        RUN       = 3'd3,
        ERROR     = 3'd4
    } state_t;

    // Reset asserts immediately and is released two edges after rstn rises.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) rst_sync <= 2'b00;
        else       rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n = rst_sync[1];

    state_t                  state, state_nxt;
    logic [LCW-1:0]          cnt, cnt_nxt;       // LOAD cycle index, 0 = first cycle in LOAD
    logic [TCW-1:0]          tmo, tmo_nxt;       // WAIT_DONE cycles elapsed
    logic                    rd_dly;             // rom_rdata is valid this cycle
    logic                    rd_nxt, load_nxt;
    logic [ADDR_WIDTH-1:0]   addr_nxt;
    logic [7:0]              loc_nxt;
    logic [63:0]             data_nxt;
    logic [31:0]             cnt_ext;

    assign cnt_ext = 32'(cnt);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        tmo_nxt   = tmo;
        rd_nxt    = 1'b0;
        addr_nxt  = rom_addr;
        load_nxt  = 1'b0;
        loc_nxt   = location;
        // Capturing the ROM word here makes mem_data trail location by one write.
        data_nxt  = rd_dly ? rom_rdata : mem_data;

        case (state)
            IDLE, RUN, ERROR: begin
                if (start) begin
                    state_nxt = LOAD;
                    cnt_nxt   = '0;
                    rd_nxt    = 1'b1;
                    addr_nxt  = ADDR_WIDTH'(BASE_ADDR);
                    data_nxt  = '0;
                end
            end
            LOAD: begin
                cnt_nxt = cnt + LCW'(1);
                if (cnt_ext + 32'd1 < 32'(N)) begin
                    rd_nxt   = 1'b1;
                    addr_nxt = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(cnt_ext + 32'd1);
                end
                // N+2 writes: the channel's done counter needs two extra strobes,
                // which repeat the last index.
                if (cnt_ext <= 32'(N + 1)) begin
                    load_nxt = 1'b1;
                    loc_nxt  = (cnt_ext < 32'(N - 1)) ? 8'(cnt_ext) : 8'(N - 1);
                end
                if (cnt_ext == 32'(N + 2)) begin
                    state_nxt = WAIT_DONE;
                    tmo_nxt   = '0;
                end
            end
            WAIT_DONE: begin
                if (done_wait)            state_nxt = RUN;
                else if (tmo == TMO_LAST) state_nxt = ERROR;
                else                      tmo_nxt   = tmo + TCW'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            tmo       <= '0;
            rd_dly    <= 1'b0;
            rom_rd_en <= 1'b0;
            rom_addr  <= '0;
            load_mem  <= 1'b0;
            location  <= '0;
            mem_data  <= '0;
            src_ready <= 1'b0;
            busy      <= 1'b0;
            cfg_done  <= 1'b0;
            cfg_error <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            tmo       <= tmo_nxt;
            rd_dly    <= rom_rd_en;
            rom_rd_en <= rd_nxt;
            rom_addr  <= addr_nxt;
            load_mem  <= load_nxt;
            location  <= loc_nxt;
            mem_data  <= data_nxt;
            // Status flags are decoded from the next state so they change on the transition edge.
            src_ready <= (state_nxt == RUN);
            busy      <= (state_nxt == LOAD) || (state_nxt == WAIT_DONE);
            cfg_done  <= (state_nxt == RUN);
            cfg_error <= (state_nxt == ERROR);
        end
    end

    assign chan_valid = src_valid & src_ready;

endmodule

// File: tb/tb_chan_coef_load_ctrl.sv
module tb_chan_coef_load_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        rom_rd_en;
    logic [7:0]  rom_addr;
    logic [63:0] rom_rdata = '0;
    logic        load_mem;
    logic [7:0]  location;
    logic [63:0] mem_data;
    logic        done_wait = 1'b0;
    logic        src_valid = 1'b0;
    logic        src_ready;
    logic        chan_valid;
    logic        busy;
    logic        cfg_done;
    logic        cfg_error;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] rom [0:255];
    int          exp_loc [0:6] = '{0, 1, 2, 3, 4, 4, 4};
    logic [63:0] exp_dat [0:6] = '{64'h0,
                                   64'h0000_0001_0000_00A1, 64'h0000_0002_0000_00A2,
                                   64'h0000_0003_0000_00A3, 64'h0000_0004_0000_00A4,
                                   64'h0000_0005_0000_00A5, 64'h0000_0005_0000_00A5};

    chan_coef_load_ctrl #(
        .PULSE_RESPONSE_LENGTH(5),
        .ADDR_WIDTH(8),
        .BASE_ADDR(0),
        .DONE_TIMEOUT(16)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start),
        .rom_rd_en(rom_rd_en), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
        .load_mem(load_mem), .location(location), .mem_data(mem_data),
        .done_wait(done_wait), .src_valid(src_valid), .src_ready(src_ready),
        .chan_valid(chan_valid), .busy(busy), .cfg_done(cfg_done), .cfg_error(cfg_error)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (rom_rd_en) rom_rdata <= rom[rom_addr];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start in cycle 0 and checks cycles 1..8; returns positioned in cycle 9.
    task automatic load_window(input bit poke, input string nm);
        int nload;
        nload = 0;
        src_valid = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            start = (poke && c == 5);
            chk($sformatf("%s c%0d rd_en", nm, c), rom_rd_en, (c <= 5));
            if (c <= 5) chk($sformatf("%s c%0d addr", nm, c), rom_addr, c - 1);
            chk($sformatf("%s c%0d load_mem", nm, c), load_mem, (c >= 2));
            if (c >= 2) begin
                chk($sformatf("%s c%0d location", nm, c), location, exp_loc[c-2]);
                chk($sformatf("%s c%0d mem_data", nm, c), mem_data, exp_dat[c-2]);
            end
            chk($sformatf("%s c%0d busy", nm, c), busy, 1);
            chk($sformatf("%s c%0d src_ready", nm, c), src_ready, 0);
            chk($sformatf("%s c%0d chan_valid", nm, c), chan_valid, 0);
            chk($sformatf("%s c%0d cfg_done", nm, c), cfg_done, 0);
            chk($sformatf("%s c%0d cfg_error", nm, c), cfg_error, 0);
            if (load_mem) nload++;
            tick();
        end
        start = 1'b0;
        chk({nm, " load count"}, nload, 7);
        chk({nm, " c9 load_mem"}, load_mem, 0);
        chk({nm, " c9 busy"}, busy, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = '0;
        rom[0] = 64'h0000_0001_0000_00A1;
        rom[1] = 64'h0000_0002_0000_00A2;
        rom[2] = 64'h0000_0003_0000_00A3;
        rom[3] = 64'h0000_0004_0000_00A4;
        rom[4] = 64'h0000_0005_0000_00A5;

        // Reset state
        src_valid = 1'b1;
        repeat (3) tick();
        chk("rst rd_en", rom_rd_en, 0);
        chk("rst addr", rom_addr, 0);
        chk("rst load_mem", load_mem, 0);
        chk("rst location", location, 0);
        chk("rst mem_data", mem_data, 0);
        chk("rst src_ready", src_ready, 0);
        chk("rst chan_valid", chan_valid, 0);
        chk("rst busy", busy, 0);
        chk("rst cfg_done", cfg_done, 0);
        chk("rst cfg_error", cfg_error, 0);
        rstn = 1'b1;
        repeat (3) tick();
        chk("idle busy", busy, 0);

        // Scenario 1/2: first load, done_wait arrives two cycles after the last write
        load_window(1'b0, "s1");
        tick();
        chk("s2 c10 busy", busy, 1);
        chk("s2 c10 chan_valid", chan_valid, 0);
        done_wait = 1'b1;
        tick();
        chk("s2 cfg_done", cfg_done, 1);
        chk("s2 src_ready", src_ready, 1);
        chk("s2 busy", busy, 0);
        src_valid = 1'b1; #1 chk("s2 chan_valid 1a", chan_valid, 1); tick();
        src_valid = 1'b0; #1 chk("s2 chan_valid 0", chan_valid, 0); tick();
        src_valid = 1'b1; #1 chk("s2 chan_valid 1b", chan_valid, 1); tick();

        // Scenario 4/5: reload from RUN with done_wait high, extra starts ignored
        load_window(1'b1, "s4");
        chk("s4 c9 src_ready", src_ready, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("s4 run src_ready", src_ready, 1);
        chk("s4 run cfg_done", cfg_done, 1);
        chk("s4 run busy", busy, 0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("s5 no restart load_mem %0d", i), load_mem, 0);
            chk($sformatf("s5 no restart rd_en %0d", i), rom_rd_en, 0);
            tick();
        end

        // Scenario 3: timeout, then retry
        done_wait = 1'b0;
        load_window(1'b0, "s3");
        for (int c = 9; c <= 24; c++) begin
            chk($sformatf("s3 wait c%0d cfg_error", c), cfg_error, 0);
            chk($sformatf("s3 wait c%0d busy", c), busy, 1);
            tick();
        end
        chk("s3 err cfg_error", cfg_error, 1);
        chk("s3 err busy", busy, 0);
        chk("s3 err src_ready", src_ready, 0);
        chk("s3 err chan_valid", chan_valid, 0);
        chk("s3 err cfg_done", cfg_done, 0);
        tick();
        chk("s3 err sticky", cfg_error, 1);
        load_window(1'b0, "s3r");
        done_wait = 1'b1;
        tick();
        chk("s3r cfg_done", cfg_done, 1);
        chk("s3r src_ready", src_ready, 1);

        // Scenario 6: reset in load cycle 4
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("s6 pre load_mem", load_mem, 1);
        chk("s6 pre location", location, 4);
        rstn = 1'b0;
        #1;
        chk("s6 async load_mem", load_mem, 0);
        chk("s6 async busy", busy, 0);
        chk("s6 async rd_en", rom_rd_en, 0);
        chk("s6 async src_ready", src_ready, 0);
        chk("s6 async chan_valid", chan_valid, 0);
        chk("s6 async location", location, 0);
        repeat (2) tick();
        rstn = 1'b1;
        done_wait = 1'b0;
        repeat (4) tick();
        chk("s6 idle busy", busy, 0);
        chk("s6 idle location", location, 0);
        chk("s6 idle mem_data", mem_data, 0);
        chk("s6 idle load_mem", load_mem, 0);
        load_window(1'b0, "s6");
        done_wait = 1'b1;
        tick();
        chk("s6 run cfg_done", cfg_done, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
